// File: rtl/noc_pkg.sv
// Shared NoC definitions for the edge network interface:
// flit geometry, header layout and the TX/RX state encodings.
package noc_pkg;

  localparam int FLIT_W  = 32;
  localparam int COORD_W = 4;
  localparam int LEN_W   = 8;

  typedef struct packed {
    logic [COORD_W-1:0] dst_row;
    logic [COORD_W-1:0] dst_col;
    logic [COORD_W-1:0] src_row;
    logic [COORD_W-1:0] src_col;
    logic [LEN_W-1:0]   len;
    logic [7:0]         rsvd;
  } hdr_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_HEAD,
    T_BODY
  } tx_state_e;

  typedef enum logic [1:0] {
    R_HEAD,
    R_BODY,
    R_DROP
  } rx_state_e;

endpackage

// File: rtl/ni_fifo.sv
// Registered FIFO for delivered payload flits; a pushed entry
// becomes visible on the read side one cycle later.
module ni_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit separates full from empty.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign valid   = !empty;
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/edge_ni.sv
// Edge network interface: packetises host traffic into the mesh
// and filters/buffers mesh traffic addressed to this node.
module edge_ni
  import noc_pkg::*;
#(
  parameter int ROW        = 1,
  parameter int COL        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [7:0]  hdr_dst,
  input  logic [7:0]  hdr_len,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] mesh_tx_data,
  output logic        mesh_tx_valid,
  input  logic        mesh_tx_ready,
  input  logic [31:0] mesh_rx_data,
  input  logic        mesh_rx_valid,
  output logic        mesh_rx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_src,
  output logic        rx_last,
  output logic [15:0] rx_misroute_cnt
);

  localparam logic [7:0] MY_ID =
    {COORD_W'(ROW), COORD_W'(COL)};
  localparam int FW = FLIT_W + 2*COORD_W + 1;

  tx_state_e  tx_q, tx_d;
  logic [7:0] dst_q, dst_d;
  logic [7:0] tlen_q, tlen_d;
  logic [7:0] tcnt_q, tcnt_d;
  hdr_t       tx_hdr;

  always_comb begin
    tx_d          = tx_q;
    dst_d         = dst_q;
    tlen_d        = tlen_q;
    tcnt_d        = tcnt_q;
    hdr_ready     = 1'b0;
    tx_ready      = 1'b0;
    mesh_tx_valid = 1'b0;
    mesh_tx_data  = '0;
    tx_hdr        = '{
      dst_row: dst_q[7:4],
      dst_col: dst_q[3:0],
      src_row: MY_ID[7:4],
      src_col: MY_ID[3:0],
      len:     tlen_q,
      rsvd:    8'h00
    };
    unique case (tx_q)
      T_IDLE: begin
        hdr_ready = 1'b1;
        if (hdr_valid) begin
          dst_d  = hdr_dst;
          tlen_d = hdr_len;
          tx_d   = T_HEAD;
        end
      end
      T_HEAD: begin
        mesh_tx_valid = 1'b1;
        mesh_tx_data  = tx_hdr;
        if (mesh_tx_ready) begin
          tcnt_d = tlen_q;
          tx_d   = (tlen_q == 8'd0) ? T_IDLE : T_BODY;
        end
      end
      T_BODY: begin
        // Payload passes straight through; no local storage.
        mesh_tx_valid = tx_valid;
        mesh_tx_data  = tx_data;
        tx_ready      = mesh_tx_ready;
        if (tx_valid && mesh_tx_ready) begin
          tcnt_d = tcnt_q - 8'd1;
          if (tcnt_q == 8'd1) tx_d = T_IDLE;
        end
      end
      default: tx_d = T_IDLE;
    endcase
  end

  rx_state_e  rx_q, rx_d;
  logic [7:0] src_q, src_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic [15:0] mis_q, mis_d;
  logic [7:0] rh_dst, rh_src, rh_len;
  logic       f_push, f_full, f_valid;
  logic [FW-1:0] f_wdata, f_rdata;

  assign rh_dst = mesh_rx_data[31:24];
  assign rh_src = mesh_rx_data[23:16];
  assign rh_len = mesh_rx_data[15:8];

  always_comb begin
    rx_d          = rx_q;
    src_d         = src_q;
    rcnt_d        = rcnt_q;
    mis_d         = mis_q;
    mesh_rx_ready = 1'b0;
    f_push        = 1'b0;
    f_wdata       = {mesh_rx_data, src_q, rcnt_q == 8'd1};
    unique case (rx_q)
      R_HEAD: begin
        mesh_rx_ready = 1'b1;
        if (mesh_rx_valid) begin
          src_d  = rh_src;
          rcnt_d = rh_len;
          if (rh_len == 8'd0) begin
            rx_d = R_HEAD;
          end else if (rh_dst == MY_ID) begin
            rx_d = R_BODY;
          end else begin
            rx_d = R_DROP;
            if (mis_q != 16'hFFFF) mis_d = mis_q + 16'd1;
          end
        end
      end
      R_DROP: begin
        mesh_rx_ready = 1'b1;
        if (mesh_rx_valid) begin
          rcnt_d = rcnt_q - 8'd1;
          if (rcnt_q == 8'd1) rx_d = R_HEAD;
        end
      end
      R_BODY: begin
        mesh_rx_ready = !f_full;
        if (mesh_rx_valid && !f_full) begin
          f_push = 1'b1;
          rcnt_d = rcnt_q - 8'd1;
          if (rcnt_q == 8'd1) rx_d = R_HEAD;
        end
      end
      default: rx_d = R_HEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q   <= T_IDLE;
      dst_q  <= '0;
      tlen_q <= '0;
      tcnt_q <= '0;
      rx_q   <= R_HEAD;
      src_q  <= '0;
      rcnt_q <= '0;
      mis_q  <= '0;
    end else begin
      tx_q   <= tx_d;
      dst_q  <= dst_d;
      tlen_q <= tlen_d;
      tcnt_q <= tcnt_d;
      rx_q   <= rx_d;
      src_q  <= src_d;
      rcnt_q <= rcnt_d;
      mis_q  <= mis_d;
    end
  end

  ni_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (f_push),
    .wdata (f_wdata),
    .full  (f_full),
    .pop   (rx_ready),
    .rdata (f_rdata),
    .valid (f_valid)
  );

  assign rx_valid        = f_valid;
  assign rx_data         = f_rdata[FW-1:9];
  assign rx_src          = f_rdata[8:1];
  assign rx_last         = f_rdata[0];
  assign rx_misroute_cnt = mis_q;

endmodule

// File: tb/tb_edge_ni.sv
// Directed bench for edge_ni at node (1,2): TX packetising,
// RX delivery, backpressure, misroute drop and reset.
module tb_edge_ni;

  logic        clk = 1'b0;
  logic        rst;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [7:0]  hdr_dst;
  logic [7:0]  hdr_len;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] mesh_tx_data;
  logic        mesh_tx_valid;
  logic        mesh_tx_ready;
  logic [31:0] mesh_rx_data;
  logic        mesh_rx_valid;
  logic        mesh_rx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_src;
  logic        rx_last;
  logic [15:0] rx_misroute_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  edge_ni #(
    .ROW        (1),
    .COL        (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hdr_valid       (hdr_valid),
    .hdr_ready       (hdr_ready),
    .hdr_dst         (hdr_dst),
    .hdr_len         (hdr_len),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .mesh_tx_data    (mesh_tx_data),
    .mesh_tx_valid   (mesh_tx_valid),
    .mesh_tx_ready   (mesh_tx_ready),
    .mesh_rx_data    (mesh_rx_data),
    .mesh_rx_valid   (mesh_rx_valid),
    .mesh_rx_ready   (mesh_rx_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .rx_src          (rx_src),
    .rx_last         (rx_last),
    .rx_misroute_cnt (rx_misroute_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int got;
    int cyc;
    logic acc;

    rst           = 1'b1;
    hdr_valid     = 1'b0;
    hdr_dst       = '0;
    hdr_len       = '0;
    tx_data       = '0;
    tx_valid      = 1'b0;
    mesh_tx_ready = 1'b0;
    mesh_rx_data  = '0;
    mesh_rx_valid = 1'b0;
    rx_ready      = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_hdr_ready", 32'(hdr_ready), 32'd1);
    chk("rst_mrx_ready", 32'(mesh_rx_ready), 32'd1);
    chk("rst_mtx_valid", 32'(mesh_tx_valid), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_miscnt", 32'(rx_misroute_cnt), 32'd0);

    // TX: dst 0x13, two payload flits, no stalls
    step();
    hdr_valid     = 1'b1;
    hdr_dst       = 8'h13;
    hdr_len       = 8'd2;
    mesh_tx_ready = 1'b1;
    step();
    hdr_valid = 1'b0;
    tx_valid  = 1'b1;
    tx_data   = 32'hA5A50001;
    #1;
    chk("tx_head_valid", 32'(mesh_tx_valid), 32'd1);
    chk("tx_head_data", mesh_tx_data, 32'h13120200);
    chk("tx_head_txrdy", 32'(tx_ready), 32'd0);
    chk("tx_head_hdrrdy", 32'(hdr_ready), 32'd0);
    step();
    #1;
    chk("tx_b1_data", mesh_tx_data, 32'hA5A50001);
    chk("tx_b1_txrdy", 32'(tx_ready), 32'd1);
    step();
    tx_data = 32'hA5A50002;
    #1;
    chk("tx_b2_data", mesh_tx_data, 32'hA5A50002);
    chk("tx_b2_valid", 32'(mesh_tx_valid), 32'd1);
    step();
    tx_valid = 1'b0;
    #1;
    chk("tx_done_hdrrdy", 32'(hdr_ready), 32'd1);
    chk("tx_done_valid", 32'(mesh_tx_valid), 32'd0);

    // TX: len 0 with a stalled header
    hdr_valid     = 1'b1;
    hdr_dst       = 8'h21;
    hdr_len       = 8'd0;
    mesh_tx_ready = 1'b0;
    step();
    hdr_valid = 1'b0;
    #1;
    chk("tx0_head_data", mesh_tx_data, 32'h21120000);
    step();
    #1;
    chk("tx0_stall_data", mesh_tx_data, 32'h21120000);
    chk("tx0_stall_valid", 32'(mesh_tx_valid), 32'd1);
    mesh_tx_ready = 1'b1;
    step();
    #1;
    chk("tx0_idle_hdrrdy", 32'(hdr_ready), 32'd1);
    chk("tx0_idle_valid", 32'(mesh_tx_valid), 32'd0);

    // RX: 3-flit packet from (1,3), host always ready
    rx_ready      = 1'b1;
    mesh_rx_valid = 1'b1;
    mesh_rx_data  = 32'h12130300;
    #1;
    chk("rx_hdr_ready", 32'(mesh_rx_ready), 32'd1);
    step();
    mesh_rx_data = 32'hB0000001;
    #1;
    chk("rx_nobypass", 32'(rx_valid), 32'd0);
    step();
    mesh_rx_data = 32'hB0000002;
    #1;
    chk("rx_f1_valid", 32'(rx_valid), 32'd1);
    chk("rx_f1_data", rx_data, 32'hB0000001);
    chk("rx_f1_src", 32'(rx_src), 32'h13);
    chk("rx_f1_last", 32'(rx_last), 32'd0);
    step();
    mesh_rx_data = 32'hB0000003;
    #1;
    chk("rx_f2_data", rx_data, 32'hB0000002);
    chk("rx_f2_last", 32'(rx_last), 32'd0);
    step();
    mesh_rx_valid = 1'b0;
    #1;
    chk("rx_f3_data", rx_data, 32'hB0000003);
    chk("rx_f3_last", 32'(rx_last), 32'd1);
    step();
    #1;
    chk("rx_drained", 32'(rx_valid), 32'd0);

    // RX: 6-flit packet against a blocked host
    rx_ready      = 1'b0;
    mesh_rx_valid = 1'b1;
    mesh_rx_data  = 32'h12130600;
    step();
    for (int i = 0; i < 4; i++) begin
      mesh_rx_data = 32'hC0000000 + 32'(i);
      #1;
      chk("rxf_accept", 32'(mesh_rx_ready), 32'd1);
      step();
    end
    mesh_rx_data = 32'hC0000004;
    #1;
    chk("rxf_full_stall", 32'(mesh_rx_ready), 32'd0);
    chk("rxf_head_data", rx_data, 32'hC0000000);
    rx_ready = 1'b1;
    sent = 4;
    got  = 0;
    cyc  = 0;
    while (got < 6 && cyc < 40) begin
      #1;
      if (rx_valid) begin
        chk("rxf_data", rx_data, 32'hC0000000 + 32'(got));
        chk("rxf_last", 32'(rx_last), 32'(got == 5));
        chk("rxf_src", 32'(rx_src), 32'h13);
        got++;
      end
      acc = mesh_rx_valid && mesh_rx_ready;
      step();
      if (acc) sent++;
      if (sent < 6) mesh_rx_data = 32'hC0000000 + 32'(sent);
      else mesh_rx_valid = 1'b0;
      cyc++;
    end
    chk("rxf_count", 32'(got), 32'd6);
    mesh_rx_valid = 1'b0;
    step();

    // RX: misrouted packet for (2,2) is dropped
    mesh_rx_valid = 1'b1;
    mesh_rx_data  = 32'h22120200;
    step();
    mesh_rx_data = 32'hE0000001;
    #1;
    chk("mis_cnt", 32'(rx_misroute_cnt), 32'd1);
    chk("mis_ready1", 32'(mesh_rx_ready), 32'd1);
    step();
    mesh_rx_data = 32'hE0000002;
    #1;
    chk("mis_ready2", 32'(mesh_rx_ready), 32'd1);
    chk("mis_novalid1", 32'(rx_valid), 32'd0);
    step();
    // len 0 header, then a 1-flit header right behind it
    mesh_rx_data = 32'h12130000;
    #1;
    chk("mis_novalid2", 32'(rx_valid), 32'd0);
    chk("len0_ready", 32'(mesh_rx_ready), 32'd1);
    step();
    mesh_rx_data = 32'h12130100;
    #1;
    chk("len0_next_rdy", 32'(mesh_rx_ready), 32'd1);
    chk("len0_novalid", 32'(rx_valid), 32'd0);
    step();
    mesh_rx_data = 32'hD0000000;
    step();
    mesh_rx_valid = 1'b0;
    #1;
    chk("len0_f_data", rx_data, 32'hD0000000);
    chk("len0_f_last", 32'(rx_last), 32'd1);
    chk("mis_cnt_keep", 32'(rx_misroute_cnt), 32'd1);
    step();

    // Reset after one of three TX payload flits
    hdr_valid = 1'b1;
    hdr_dst   = 8'h13;
    hdr_len   = 8'd3;
    step();
    hdr_valid = 1'b0;
    tx_valid  = 1'b1;
    tx_data   = 32'hF0000001;
    step();
    step();
    tx_data = 32'hF0000002;
    #1;
    chk("mid_body_valid", 32'(mesh_tx_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(mesh_tx_valid), 32'd0);
    chk("mid_rst_hdrrdy", 32'(hdr_ready), 32'd1);
    chk("mid_rst_miscnt", 32'(rx_misroute_cnt), 32'd0);
    chk("mid_rst_txrdy", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
